// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads the bubble, hold keeps the current entry.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            hold,
   input  logic            flush,
   input  logic [XLEN-1:0] pc_in,
   input  logic [31:0]     instr_in,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            valid
);

   logic [XLEN-1:0] pc_d, pc_q;
   logic [31:0]     instr_d, instr_q;
   logic            valid_d, valid_q;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush) begin
         pc_d    = '0;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!hold) begin
         pc_d    = pc_in;
         instr_d = instr_in;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc    = pc_q;
   assign instr = instr_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, fetch FSM and IF/ID capture.
// Optional IF_MISALIGN_CHECK_EN traps redirects to non-word-aligned targets.
//
// state | meaning
// BOOT  | first cycle after reset, PC holds RESET_PC, IF/ID holds bubble
// RUN   | fetching sequentially, honouring stall and redirect
// HALT  | all-zero word fetched (or misaligned redirect); only redirect/reset exit
module fetch_stage
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_pc,
   input  logic [31:0]     imem_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic            if_id_valid,
`ifdef IF_MISALIGN_CHECK_EN
   output logic            misaligned,
`endif
   output logic            halted
);

   state_e          state_d, state_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic            halted_d, halted_q;
   logic            mis_d, mis_q;
   logic            ifid_hold, ifid_flush;
   logic [XLEN-1:0] redirect_target;
   logic            redirect_mis;

`ifdef IF_MISALIGN_CHECK_EN
   assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
   assign redirect_mis    = (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_target = redirect_pc;
   assign redirect_mis    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mis_d      = mis_q;
      ifid_hold  = 1'b1;
      ifid_flush = 1'b0;
      // Redirect has top priority in every state; flushing an existing bubble is harmless.
      if (redirect) begin
         pc_d       = redirect_target;
         ifid_flush = 1'b1;
         state_d    = RUN;
         if (redirect_mis) begin
            mis_d   = 1'b1;
            state_d = HALT;
         end
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               if (stall) begin
                  ifid_hold = 1'b1;
               end else if (imem_instr == 32'h0) begin
                  ifid_flush = 1'b1;
                  state_d    = HALT;
               end else begin
                  ifid_hold = 1'b0;
                  pc_d      = pc_q + PC_STEP;
               end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
         endcase
      end
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         mis_q    <= mis_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .hold     (ifid_hold),
      .flush    (ifid_flush),
      .pc_in    (pc_q),
      .instr_in (imem_instr),
      .pc       (if_id_pc),
      .instr    (if_id_instr),
      .valid    (if_id_valid)
   );

   assign imem_pc = pc_q;
   assign halted  = halted_q;

`ifdef IF_MISALIGN_CHECK_EN
   assign misaligned = mis_q;
`else
   logic unused_mis;
   assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; define IF_MISALIGN_CHECK_EN to exercise the misalign trap.
module tb_fetch_stage;
   import fetch_pkg::*;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        halted;
`ifdef IF_MISALIGN_CHECK_EN
   logic        misaligned;
`endif

   logic [31:0] mem [0:15];
   int          n_tests = 0;
   int          n_fail  = 0;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_pc     (imem_pc),
      .imem_instr  (imem_instr),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
`ifdef IF_MISALIGN_CHECK_EN
      .misaligned  (misaligned),
`endif
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_instr = mem[imem_pc[5:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".imem_pc"}, imem_pc, 32'h0);
      chk({tag, ".if_id_pc"}, if_id_pc, 32'h0);
      chk({tag, ".if_id_instr"}, if_id_instr, 32'h0000_0013);
      chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'h0);
      chk({tag, ".halted"}, {31'b0, halted}, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
      chk({tag, ".misaligned"}, {31'b0, misaligned}, 32'h0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = {i[11:0] + 12'd1, 20'h00093};
      mem[0] = 32'h0031_00B3;
      reset = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;

      #12;
      chk_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;

      // Boot and first capture
      tick();
      chk("boot.imem_pc", imem_pc, 32'h0);
      chk("boot.valid", {31'b0, if_id_valid}, 32'h0);
      tick();
      chk("run1.if_id_pc", if_id_pc, 32'h0);
      chk("run1.if_id_instr", if_id_instr, 32'h0031_00B3);
      chk("run1.valid", {31'b0, if_id_valid}, 32'h1);
      chk("run1.imem_pc", imem_pc, 32'h4);
      tick();
      chk("run2.imem_pc", imem_pc, 32'h8);
      chk("run2.if_id_instr", if_id_instr, 32'h0020_0093);

      // Stall for three cycles at PC 8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall.imem_pc", imem_pc, 32'h8);
         chk("stall.if_id_pc", if_id_pc, 32'h4);
      end
      stall = 1'b0;
      tick();
      chk("unstall.if_id_pc", if_id_pc, 32'h8);
      chk("unstall.imem_pc", imem_pc, 32'hC);

      // Redirect beats stall
      redirect = 1'b1;
      redirect_pc = 32'h14;
      stall = 1'b1;
      tick();
      chk("redir.imem_pc", imem_pc, 32'h14);
      chk("redir.valid", {31'b0, if_id_valid}, 32'h0);
      chk("redir.if_id_instr", if_id_instr, 32'h0000_0013);
      redirect = 1'b0;
      stall = 1'b0;
      tick();
      chk("redir2.if_id_pc", if_id_pc, 32'h14);
      chk("redir2.if_id_instr", if_id_instr, 32'h0060_0093);
      chk("redir2.valid", {31'b0, if_id_valid}, 32'h1);
      chk("redir2.imem_pc", imem_pc, 32'h18);

      // Halt on zero word at PC 8
      mem[2] = 32'h0;
      redirect = 1'b1;
      redirect_pc = 32'h8;
      tick();
      chk("hredir.imem_pc", imem_pc, 32'h8);
      redirect = 1'b0;
      tick();
      chk("halt.halted", {31'b0, halted}, 32'h1);
      chk("halt.valid", {31'b0, if_id_valid}, 32'h0);
      chk("halt.imem_pc", imem_pc, 32'h8);
      stall = 1'b1;
      tick();
      chk("halt_stall.halted", {31'b0, halted}, 32'h1);
      chk("halt_stall.imem_pc", imem_pc, 32'h8);
      stall = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0;
      tick();
      chk("rescue.halted", {31'b0, halted}, 32'h0);
      chk("rescue.imem_pc", imem_pc, 32'h0);
      redirect = 1'b0;
      mem[2] = 32'h0030_0093;
      tick();
      chk("rescue2.valid", {31'b0, if_id_valid}, 32'h1);
      chk("rescue2.imem_pc", imem_pc, 32'h4);
      tick();
      tick();
      tick();
      chk("pre_rst.imem_pc", imem_pc, 32'h10);
      chk("pre_rst.valid", {31'b0, if_id_valid}, 32'h1);

      // Asynchronous reset between edges
      #3;
      reset = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      #2;
      reset = 1'b1;

      // PC wrap
      tick();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      chk("wrap.imem_pc", imem_pc, 32'hFFFF_FFFC);
      redirect = 1'b0;
      tick();
      chk("wrap2.imem_pc", imem_pc, 32'h0);
      chk("wrap2.if_id_pc", if_id_pc, 32'hFFFF_FFFC);
      chk("wrap2.if_id_instr", if_id_instr, 32'h0100_0093);

      // Misaligned redirect
      redirect = 1'b1;
      redirect_pc = 32'h16;
      tick();
      redirect = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      chk("mis.misaligned", {31'b0, misaligned}, 32'h1);
      chk("mis.imem_pc", imem_pc, 32'h14);
      chk("mis.halted", {31'b0, halted}, 32'h1);
      tick();
      chk("mis2.imem_pc", imem_pc, 32'h14);
      chk("mis2.valid", {31'b0, if_id_valid}, 32'h0);
`else
      chk("mis.imem_pc", imem_pc, 32'h16);
      chk("mis.halted", {31'b0, halted}, 32'h0);
      tick();
      chk("mis2.if_id_pc", if_id_pc, 32'h16);
      chk("mis2.valid", {31'b0, if_id_valid}, 32'h1);
      chk("mis2.imem_pc", imem_pc, 32'h1A);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Owns the program counter, drives the fetch address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Handles hazard stalls, branch/jump redirects with flush, and a halt on an all-zero fetched word.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on reset/flush/halt
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  from hazard unit; hold PC and IF/ID
- redirect  in  1  from EX; taken branch/jump this cycle
- redirect_pc  in  XLEN  redirect target
- imem_pc  out  XLEN  fetch address to instruction memory (= PC register)
- imem_instr  in  32  instruction word returned combinationally for imem_pc
- if_id_pc  out  XLEN  PC of instruction held in IF/ID
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  stage is in HALT
- misaligned  out  1  sticky misaligned-redirect flag (only with IF_MISALIGN_CHECK_EN)

## Operation
- FSM states: BOOT, RUN, HALT. Reset -> BOOT.
- BOOT: first rising edge after reset release -> RUN; PC unchanged, IF/ID unchanged (bubble). Redirect in BOOT: PC <= redirect_pc, -> RUN.
- RUN, per edge, priority highest first:
  - redirect: PC <= redirect_pc; IF/ID <= bubble (valid 0, instr NOP_INSTR, pc 0).
  - stall: PC and IF/ID hold.
  - imem_instr == 32'h0: IF/ID <= bubble; PC holds; -> HALT.
  - else: IF/ID <= {imem_pc, imem_instr, valid 1}; PC <= PC + 4 (mod 2^XLEN, wraps 32'hFFFF_FFFC -> 0).
- HALT: PC and IF/ID hold bubble; stall ignored; redirect -> PC <= redirect_pc, -> RUN (older branch still in flight may rescue). Only reset or redirect exits.
- halted = (state == HALT), registered-state decode.

## Timing
- Reset values: imem_pc = RESET_PC, if_id_pc = 0, if_id_instr = NOP_INSTR, if_id_valid = 0, halted = 0, misaligned = 0.
- imem_pc is the PC register output; memory read is combinational in the same cycle; capture is one edge later. Fetch-to-IF/ID latency: 1 cycle.
- Redirect asserted in cycle N: target on imem_pc in N+1, target instruction in IF/ID after edge N+1; exactly one wrong-path slot flushed.
- redirect and stall together: redirect wins.
- Reset assertion mid-operation returns all outputs to reset values immediately (asynchronous), independent of clk.

## Configuration
- IF_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets misaligned (sticky until reset), loads PC <= {redirect_pc[XLEN-1:2],2'b00}, flushes IF/ID, -> HALT.
- Undefined: misaligned port absent; redirect_pc loaded verbatim (byte-addressed memory tolerates it).

## Structure
- Package fetch_pkg: XLEN, NOP_INSTR, PC_STEP (4), state enum {BOOT, RUN, HALT}.
- One sub-module: if_id_reg (pc/instr/valid register with hold and flush inputs, async active-low reset to bubble); FSM and PC logic stay in fetch_stage.

## Test plan
- Reset release, imem word0 = 32'h0031_00B3 (add x1,x2,x3): edge1 BOOT->RUN, imem_pc 0; edge2 if_id_pc 0, if_id_instr 32'h0031_00B3, valid 1, imem_pc 4.
- Stall high 3 cycles during RUN at PC 8 -> imem_pc stays 8, IF/ID unchanged; release -> resumes 8, 12.
- Redirect to 32'h14 with stall high at PC 12 -> next edge imem_pc 32'h14, if_id_valid 0, if_id_instr NOP_INSTR; following edge captures word at 32'h14, valid 1.
- Fetch word 32'h0 at PC 8 -> halted 1, valid 0, imem_pc holds 8; redirect to 0 -> RUN, imem_pc 0.
- Assert reset mid-run (PC 32'h10, valid 1) between edges -> all outputs at reset values immediately.
- With IF_MISALIGN_CHECK_EN: redirect to 32'h16 -> misaligned 1, imem_pc 32'h14, halted 1; without macro imem_pc 32'h16, RUN.
